// File: rtl/regfile_banked.sv
// regfile_banked: NUM_BANKS x DEPTH register file, NUM_RD read ports, pending bits.
// Optional REGFILE_BYPASS_EN: same-cycle write-through from write port to reads.
module regfile_banked #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int NUM_BANKS = 2,
  parameter int NUM_RD    = 3,
  parameter int ZERO_BANK = 0,
  localparam int BANK_W   = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     init_done,
  input  logic [NUM_RD*BANK_W-1:0] rd_bank,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_pend,
  input  logic                     wr_en,
  input  logic [BANK_W-1:0]        wr_bank,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rsv_en,
  input  logic [BANK_W-1:0]        rsv_bank,
  input  logic [ADDR_W-1:0]        rsv_addr
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {INIT, RUN} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]   mem  [NUM_BANKS][DEPTH];
  logic [DEPTH-1:0]    pend [NUM_BANKS];
  logic                run;
  logic                wr_ok;
  logic                rsv_ok;

  function automatic logic bank_ok(input logic [BANK_W-1:0] b);
    return 32'(b) < 32'(NUM_BANKS);
  endfunction

  function automatic logic is_zero(input logic [BANK_W-1:0] b,
                                   input logic [ADDR_W-1:0] a);
    return (ZERO_BANK < NUM_BANKS) &&
           (32'(b) == 32'(ZERO_BANK)) && (a == '0);
  endfunction

  assign run       = (state_q == RUN);
  assign init_done = run;
  assign wr_ok     = run && wr_en && bank_ok(wr_bank) &&
                     !is_zero(wr_bank, wr_addr);
  assign rsv_ok    = run && rsv_en && bank_ok(rsv_bank) &&
                     !is_zero(rsv_bank, rsv_addr);

  // State and sweep index register; reset restarts the sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Sweep sequencing: leave INIT after clearing the last entry.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      INIT: begin
        idx_d = idx_q + ADDR_W'(1);
        if (&idx_q) state_d = RUN;
      end
      RUN: begin
        idx_d = idx_q;
      end
      default: state_d = INIT;
    endcase
  end

  // Storage update: sweep clears, else write then reservation (reservation wins).
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (!run) begin
        for (int b = 0; b < NUM_BANKS; b++) begin
          mem[b][idx_q]  <= '0;
          pend[b][idx_q] <= 1'b0;
        end
      end else begin
        if (wr_ok) begin
          mem[wr_bank][wr_addr]  <= wr_data;
          pend[wr_bank][wr_addr] <= 1'b0;
        end
        if (rsv_ok) begin
          pend[rsv_bank][rsv_addr] <= 1'b1;
        end
      end
    end
  end

  // Combinational read ports with zero/range masking and optional forwarding.
  always_comb begin
    rd_data = '0;
    rd_pend = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (run &&
          bank_ok(rd_bank[i*BANK_W +: BANK_W]) &&
          !is_zero(rd_bank[i*BANK_W +: BANK_W],
                   rd_addr[i*ADDR_W +: ADDR_W])) begin
        rd_data[i*DATA_W +: DATA_W] =
          mem[rd_bank[i*BANK_W +: BANK_W]][rd_addr[i*ADDR_W +: ADDR_W]];
        rd_pend[i] =
          pend[rd_bank[i*BANK_W +: BANK_W]][rd_addr[i*ADDR_W +: ADDR_W]];
`ifdef REGFILE_BYPASS_EN
        if (wr_en &&
            rd_bank[i*BANK_W +: BANK_W] == wr_bank &&
            rd_addr[i*ADDR_W +: ADDR_W] == wr_addr) begin
          rd_data[i*DATA_W +: DATA_W] = wr_data;
          rd_pend[i] = 1'b0;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_regfile_banked.sv
// tb_regfile_banked: random + directed stimulus against an array-based model.
// Expected read responses are queued by the driver and checked by a monitor.
module tb_regfile_banked;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NB = 2;
  localparam int NR = 3;
  localparam int BW = 1;
  localparam int DEPTH = 32;

  logic               clk = 1'b0;
  logic               rst;
  logic               init_done;
  logic [NR*BW-1:0]   rd_bank;
  logic [NR*AW-1:0]   rd_addr;
  logic [NR*DW-1:0]   rd_data;
  logic [NR-1:0]      rd_pend;
  logic               wr_en;
  logic [BW-1:0]      wr_bank;
  logic [AW-1:0]      wr_addr;
  logic [DW-1:0]      wr_data;
  logic               rsv_en;
  logic [BW-1:0]      rsv_bank;
  logic [AW-1:0]      rsv_addr;

  regfile_banked dut (
    .clk(clk), .rst(rst), .init_done(init_done),
    .rd_bank(rd_bank), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_pend(rd_pend),
    .wr_en(wr_en), .wr_bank(wr_bank),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_bank(rsv_bank),
    .rsv_addr(rsv_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          done;
    logic [DW-1:0] data [NR];
    logic          pend [NR];
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  logic [DW-1:0] mdata [NB][DEPTH];
  logic          mpend [NB][DEPTH];
  logic          mrun;
  int            mcnt;

  function automatic logic zero_reg(input int b, input int a);
    return (b == 0) && (a == 0);
  endfunction

  task automatic model_clear();
    for (int b = 0; b < NB; b++)
      for (int a = 0; a < DEPTH; a++) begin
        mdata[b][a] = '0;
        mpend[b][a] = 1'b0;
      end
  endtask

  task automatic cyc(input logic r,
                     input logic we, input int wb, input int wa,
                     input logic [DW-1:0] wd,
                     input logic re, input int sb, input int sa,
                     input int b0, input int a0,
                     input int b1, input int a1,
                     input int b2, input int a2);
    int   rb [NR];
    int   ra [NR];
    exp_t e;
    rb[0] = b0; rb[1] = b1; rb[2] = b2;
    ra[0] = a0; ra[1] = a1; ra[2] = a2;
    rst      = r;
    wr_en    = we;
    wr_bank  = BW'(wb);
    wr_addr  = AW'(wa);
    wr_data  = wd;
    rsv_en   = re;
    rsv_bank = BW'(sb);
    rsv_addr = AW'(sa);
    for (int i = 0; i < NR; i++) begin
      rd_bank[i*BW +: BW] = BW'(rb[i]);
      rd_addr[i*AW +: AW] = AW'(ra[i]);
    end
    e.done = mrun;
    for (int i = 0; i < NR; i++) begin
      e.data[i] = '0;
      e.pend[i] = 1'b0;
      if (mrun && rb[i] < NB && !zero_reg(rb[i], ra[i])) begin
        e.data[i] = mdata[rb[i]][ra[i]];
        e.pend[i] = mpend[rb[i]][ra[i]];
`ifdef REGFILE_BYPASS_EN
        if (we && wb == rb[i] && wa == ra[i]) begin
          e.data[i] = wd;
          e.pend[i] = 1'b0;
        end
`endif
      end
    end
    q.push_back(e);
    @(posedge clk);
    if (r) begin
      mrun = 1'b0;
      mcnt = 0;
    end else if (!mrun) begin
      mcnt++;
      if (mcnt == DEPTH) begin
        mrun = 1'b1;
        model_clear();
      end
    end else begin
      if (we && wb < NB && !zero_reg(wb, wa)) begin
        mdata[wb][wa] = wd;
        mpend[wb][wa] = 1'b0;
      end
      if (re && sb < NB && !zero_reg(sb, sa))
        mpend[sb][sa] = 1'b1;
    end
    #1;
  endtask

  task automatic rnd(input logic r, input int amax);
    cyc(r,
        1'($urandom_range(0, 1)), $urandom_range(0, 1),
        $urandom_range(0, amax), $urandom,
        1'($urandom_range(0, 1)), $urandom_range(0, 1),
        $urandom_range(0, amax),
        $urandom_range(0, 1), $urandom_range(0, amax),
        $urandom_range(0, 1), $urandom_range(0, amax),
        $urandom_range(0, 1), $urandom_range(0, amax));
  endtask

  task automatic rd3(input int b, input int a);
    cyc(1'b0, 1'b0, 0, 0, '0, 1'b0, 0, 0, b, a, b, a, b, a);
  endtask

  task automatic scan();
    for (int a = 0; a < DEPTH; a++)
      cyc(1'b0, 1'b0, 0, 0, '0, 1'b0, 0, 0, 0, a, 1, a, 1, a);
  endtask

  // Monitor: the DUT presents read data every cycle; compare mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (init_done !== e.done) begin
          failures++;
          $display("FAIL init_done got %0b want %0b t=%0t",
                   init_done, e.done, $time);
        end
        for (int i = 0; i < NR; i++) begin
          checks++;
          if (rd_data[i*DW +: DW] !== e.data[i]) begin
            failures++;
            $display("FAIL rd_data[%0d] got %08h want %08h t=%0t",
                     i, rd_data[i*DW +: DW], e.data[i], $time);
          end
          checks++;
          if (rd_pend[i] !== e.pend[i]) begin
            failures++;
            $display("FAIL rd_pend[%0d] got %0b want %0b t=%0t",
                     i, rd_pend[i], e.pend[i], $time);
          end
        end
      end
    end
  end

  initial begin
    mrun = 1'b0;
    mcnt = 0;
    model_clear();
    rst = 1'b1;
    wr_en = 1'b0; wr_bank = '0; wr_addr = '0; wr_data = '0;
    rsv_en = 1'b0; rsv_bank = '0; rsv_addr = '0;
    rd_bank = '0; rd_addr = '0;
    @(posedge clk);
    #1;
    repeat (3) rnd(1'b1, 31);
    repeat (10) rnd(1'b0, 31);
    repeat (2) rnd(1'b1, 31);
    repeat (40) rnd(1'b0, 31);
    scan();

    cyc(1'b0, 1'b1, 0, 5, 32'hDEADBEEF, 1'b0, 0, 0, 0, 5, 1, 5, 0, 5);
    cyc(1'b0, 1'b1, 1, 5, 32'h3F800000, 1'b0, 0, 0, 0, 5, 1, 5, 1, 5);
    rd3(0, 5);
    rd3(1, 5);
    cyc(1'b0, 1'b1, 0, 0, 32'hFFFFFFFF, 1'b1, 0, 0, 0, 0, 0, 0, 0, 0);
    rd3(0, 0);
    cyc(1'b0, 1'b1, 1, 0, 32'h12345678, 1'b0, 0, 0, 1, 0, 1, 0, 1, 0);
    rd3(1, 0);
    cyc(1'b0, 1'b0, 0, 0, '0, 1'b1, 0, 7, 0, 7, 0, 7, 0, 7);
    rd3(0, 7);
    cyc(1'b0, 1'b1, 0, 7, 32'hA5, 1'b0, 0, 0, 0, 7, 0, 7, 0, 7);
    rd3(0, 7);
    cyc(1'b0, 1'b1, 0, 9, 32'hA5, 1'b1, 0, 9, 0, 9, 0, 9, 0, 9);
    rd3(0, 9);
    cyc(1'b0, 1'b1, 0, 3, 32'h11, 1'b0, 0, 0, 0, 3, 0, 3, 0, 3);
    cyc(1'b0, 1'b1, 0, 3, 32'h55, 1'b0, 0, 0, 0, 3, 0, 3, 0, 3);
    rd3(0, 3);
    cyc(1'b0, 1'b1, 1, 3, 32'h77, 1'b0, 0, 0, 0, 3, 1, 3, 0, 3);
    rd3(1, 3);

    repeat (400) rnd(1'b0, 7);
    repeat (400) rnd(1'b0, 31);
    rnd(1'b1, 31);
    repeat (40) rnd(1'b0, 31);
    scan();
    repeat (50) rnd(1'b0, 3);

    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
